prefetch_fetcher: RTL

//   Instruction fetch stage with a DEPTH-entry prefetch queue.
//   - Runs ahead of the decoder: issues sequential word fetches to the instruction memory port while queue space remains.
//   - Supports redirect (branch/jump/trap): flushes the queue and discards any stale in-flight response.
//   - Sits between the memory arbiter and the decoder; successor of the single-entry, non-redirectable fetcher.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/prefetch_fetcher.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the prefetching instruction fetcher.
//   fetch_state_t : request FSM state (IDLE, WAIT, DRAIN)
//   fetch_entry_t : one prefetch queue entry {pc, instr}
//   INSTR_BYTES   : fetch stride in bytes
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned FETCH_XLEN  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch queue.
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : write push_data at the tail
//   pop          : drop the head entry
//   flush        : empty the queue (wins over push/pop)
//   head         : current head entry (registered storage)
//   count        : number of valid entries, 0..DEPTH
module fetch_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic [63:0]
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  input  logic                       flush,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head view reads zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/prefetch_fetcher.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue.
// Issues sequential word fetches while queue space remains, one request outstanding at a time.
// A redirect flushes the queue and discards any in-flight response.
//   clk, reset_n            : clock, asynchronous active-low reset
//   redirect_valid/_pc      : restart fetch at redirect_pc (word aligned)
//   decoder_ready           : decoder consumes the head entry
//   fetcher_valid/instr/pc  : head entry view
//   mem_ready/instr/addr    : one-cycle request strobe, fetch tag, address
//   mem_wstrb               : always zero (reads only)
//   mem_valid/mem_rdata     : response strobe and data
module prefetch_fetcher
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            decoder_ready,
  output logic            fetcher_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] fetcher_pc,
  output logic            mem_ready,
  output logic            mem_instr,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned CntW     = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            mem_ready_q, mem_ready_d;

  logic            push, pop;
  fetch_entry_t    head;
  logic [CntW-1:0] fifo_count;

  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];

  assign fetcher_valid = (fifo_count != '0);
  assign pop           = fetcher_valid && decoder_ready && !redirect_valid;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    mem_addr_d  = mem_addr_q;
    mem_ready_d = 1'b0;
    push        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Space is reserved at issue time, so the eventual push cannot overflow.
        if (!redirect_valid && (fifo_count < DepthCnt)) begin
          mem_ready_d = 1'b1;
          mem_addr_d  = fetch_pc_q;
          req_pc_d    = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + XLEN'(INSTR_BYTES);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (mem_valid) begin
          push    = !redirect_valid;
          state_d = IDLE;
        end else if (redirect_valid) begin
          // Response still owed; swallow it before issuing again.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      mem_addr_q  <= '0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ('{pc: req_pc_q, instr: mem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign instr      = head.instr;
  assign fetcher_pc = head.pc;
  assign mem_ready  = mem_ready_q;
  assign mem_instr  = mem_ready_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = 4'b0000;

endmodule
